// File: rtl/sumador_pkg.sv
// sumador_pkg: shared constants for the adder board display path.
//   - Active-low seven-segment glyphs for hex digits 0-F, bit order {g,f,e,d,c,b,a}
//   - SEG_BLANK: all segments off
//   - seg7(): nibble to active-low segment pattern
package sumador_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index n holds the glyph for hex digit n; b and d are lowercase shapes.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, // F
    7'h06, // E
    7'h21, // d
    7'h46, // C
    7'h03, // b
    7'h08, // A
    7'h10, // 9
    7'h00, // 8
    7'h78, // 7
    7'h02, // 6
    7'h12, // 5
    7'h19, // 4
    7'h30, // 3
    7'h24, // 2
    7'h79, // 1
    7'h40  // 0
  };

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    return GLYPHS[nib];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: raw button to single-cycle press pulse.
//   clk_pi    in  system clock
//   rst_pi    in  synchronous active-high reset
//   btn_pi    in  raw, bouncing, asynchronous button level
//   pulse_po  out one-cycle pulse on the accepted rising edge of the level
// The accepted level follows the synchronised input only after it has
// disagreed for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts
// the count. Latency from a stable raw edge to pulse_po is DEBOUNCE_CYC+2.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 270000
) (
  input  logic clk_pi,
  input  logic rst_pi,
  input  logic btn_pi,
  output logic pulse_po
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_pi;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db_d    = sync2_q;
        pulse_d = sync2_q;  // rising edge only; release produces no pulse
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_po = pulse_q;

endmodule

// File: rtl/sumador_acc_mux.sv
// sumador_acc_mux: debounced add/subtract accumulator with multiplexed
// hex display.
//   clk_pi            in  system clock
//   rst_pi            in  synchronous active-high reset
//   dipswitch         in  IN_W   unsigned operand, asynchronous
//   suma_btn          in  add button, raw
//   resta_btn         in  subtract button, raw
//   acumulador_total  out ACC_W  accumulator value
//   overflow_po       out sticky wrap/saturation flag
//   anodo_po          out DIGITS one-hot-low digit enables
//   catodo_po         out 7      active-low segments {g,f,e,d,c,b,a}
// SAT=0 wraps modulo 2^ACC_W, SAT=1 clamps to 0 / all ones.
// Build option SUMADOR_LEAD_BLANK_EN: blank leading-zero digits (digit 0
// always shown). Undefined: every digit is shown.
module sumador_acc_mux
  import sumador_pkg::*;
#(
  parameter int IN_W         = 4,
  parameter int ACC_W        = 16,
  parameter int DIGITS       = 4,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int SCAN_CYC     = 27000,
  parameter int SAT          = 0
) (
  input  logic              clk_pi,
  input  logic              rst_pi,
  input  logic [IN_W-1:0]   dipswitch,
  input  logic              suma_btn,
  input  logic              resta_btn,
  output logic [ACC_W-1:0]  acumulador_total,
  output logic              overflow_po,
  output logic [DIGITS-1:0] anodo_po,
  output logic [6:0]        catodo_po
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

  logic add_pulse, sub_pulse;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_suma (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .btn_pi(suma_btn), .pulse_po(add_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_resta (
    .clk_pi(clk_pi), .rst_pi(rst_pi), .btn_pi(resta_btn), .pulse_po(sub_pulse)
  );

  logic [IN_W-1:0]   dip1_q, dip1_d, dip2_q, dip2_d;
  logic [ACC_W-1:0]  acc_q, acc_d, op;
  logic              ov_q, ov_d;
  logic [ACC_W:0]    sum_ext, diff_ext;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] anodo_q, anodo_d;
  logic [6:0]        catodo_q, catodo_d;
  logic [3:0]        nib;

  // Accumulator: the extra top bit of sum/diff is the carry or borrow.
  always_comb begin
    dip1_d   = dipswitch;
    dip2_d   = dip1_q;
    op       = ACC_W'(dip2_q);
    sum_ext  = {1'b0, acc_q} + {1'b0, op};
    diff_ext = {1'b0, acc_q} - {1'b0, op};
    acc_d    = acc_q;
    ov_d     = ov_q;
    if (add_pulse && !sub_pulse) begin
      acc_d = sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W]) begin
        ov_d = 1'b1;
        if (SAT != 0) acc_d = '1;
      end
    end else if (sub_pulse && !add_pulse) begin
      acc_d = diff_ext[ACC_W-1:0];
      if (diff_ext[ACC_W]) begin
        ov_d = 1'b1;
        if (SAT != 0) acc_d = '0;
      end
    end
  end

  // Scan: drive registers load from idx_q, so the lit digit lags the index
  // by one cycle and digit 0 appears on the first cycle out of reset.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_CYC - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    anodo_d  = ~(DIGITS'(1) << idx_q);
    nib      = acc_q[{idx_q, 2'b00} +: 4];
    catodo_d = seg7(nib);
`ifdef SUMADOR_LEAD_BLANK_EN
    // Blank when this nibble and everything above it are zero.
    if ((idx_q != '0) && ((acc_q >> {idx_q, 2'b00}) == '0)) catodo_d = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      dip1_q     <= '0;
      dip2_q     <= '0;
      acc_q      <= '0;
      ov_q       <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      anodo_q    <= '1;
      catodo_q   <= SEG_BLANK;
    end else begin
      dip1_q     <= dip1_d;
      dip2_q     <= dip2_d;
      acc_q      <= acc_d;
      ov_q       <= ov_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      anodo_q    <= anodo_d;
      catodo_q   <= catodo_d;
    end
  end

  assign acumulador_total = acc_q;
  assign overflow_po      = ov_q;
  assign anodo_po         = anodo_q;
  assign catodo_po        = catodo_q;

endmodule

// File: tb/tb_sumador_acc_mux.sv
// Bench for sumador_acc_mux. Three instances share the inputs:
//   u_w16: defaults (16-bit wrap, 4 digits) with short debounce/scan
//   u_w4 : 4-bit wrap, 1 digit, so carry-out is reachable in a few presses
//   u_s4 : 4-bit saturate, 1 digit, so both clamps are reachable quickly
module tb_sumador_acc_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dipswitch;
  logic        suma_btn, resta_btn;

  logic [15:0] acc_w16;
  logic        ov_w16;
  logic [3:0]  an_w16;
  logic [6:0]  cat_w16;
  logic [3:0]  acc_w4, acc_s4;
  logic        ov_w4, ov_s4;
  logic [0:0]  an_w4, an_s4;
  logic [6:0]  cat_w4, cat_s4;

  always #5 clk = ~clk;

  sumador_acc_mux #(.DEBOUNCE_CYC(4), .SCAN_CYC(8)) u_w16 (
    .clk_pi(clk), .rst_pi(rst), .dipswitch(dipswitch), .suma_btn(suma_btn),
    .resta_btn(resta_btn), .acumulador_total(acc_w16), .overflow_po(ov_w16),
    .anodo_po(an_w16), .catodo_po(cat_w16));

  sumador_acc_mux #(.ACC_W(4), .DIGITS(1), .DEBOUNCE_CYC(4), .SCAN_CYC(8), .SAT(0)) u_w4 (
    .clk_pi(clk), .rst_pi(rst), .dipswitch(dipswitch), .suma_btn(suma_btn),
    .resta_btn(resta_btn), .acumulador_total(acc_w4), .overflow_po(ov_w4),
    .anodo_po(an_w4), .catodo_po(cat_w4));

  sumador_acc_mux #(.ACC_W(4), .DIGITS(1), .DEBOUNCE_CYC(4), .SCAN_CYC(8), .SAT(1)) u_s4 (
    .clk_pi(clk), .rst_pi(rst), .dipswitch(dipswitch), .suma_btn(suma_btn),
    .resta_btn(resta_btn), .acumulador_total(acc_s4), .overflow_po(ov_s4),
    .anodo_po(an_s4), .catodo_po(cat_s4));

  typedef enum int {OP_ADD, OP_SUB, OP_BOTH, OP_RST} op_e;

  typedef struct {
    op_e         kind;
    logic [3:0]  dip;
    logic [15:0] w16;
    logic        w16_ov;
    logic [3:0]  w4;
    logic        w4_ov;
    logic [3:0]  s4;
    logic        s4_ov;
  } vec_t;

  vec_t vecs[10];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one table row; the expectation is queued at drive time and popped
  // once the operation should have landed (DEBOUNCE_CYC+3 = 7 cycles).
  task automatic do_op(input int idx, input vec_t v);
    vec_t e;
    if (v.kind == OP_RST) begin
      exp_q.push_back(v);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(1);
    end else begin
      dipswitch = v.dip;
      cyc(3);
      exp_q.push_back(v);
      suma_btn  = (v.kind == OP_ADD) || (v.kind == OP_BOTH);
      resta_btn = (v.kind == OP_SUB) || (v.kind == OP_BOTH);
      cyc(7);
    end
    e = exp_q.pop_front();
    chk($sformatf("vec%0d_acc16", idx), 32'(acc_w16), 32'(e.w16));
    chk($sformatf("vec%0d_ov16", idx), 32'(ov_w16), 32'(e.w16_ov));
    chk($sformatf("vec%0d_acc4w", idx), 32'(acc_w4), 32'(e.w4));
    chk($sformatf("vec%0d_ov4w", idx), 32'(ov_w4), 32'(e.w4_ov));
    chk($sformatf("vec%0d_acc4s", idx), 32'(acc_s4), 32'(e.s4));
    chk($sformatf("vec%0d_ov4s", idx), 32'(ov_s4), 32'(e.s4_ov));
    if (v.kind != OP_RST) begin
      cyc(5);
      suma_btn  = 1'b0;
      resta_btn = 1'b0;
      cyc(10);
    end
  endtask

  task automatic press_add(input logic [3:0] d);
    dipswitch = d;
    cyc(3);
    suma_btn = 1'b1;
    cyc(12);
    suma_btn = 1'b0;
    cyc(10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an_prev;
    logic [6:0] glyph [4];
    logic       found;

    // start 5/0 on all three instances after the two hand sequences
    vecs[0] = '{OP_BOTH, 4'h7, 16'h0005, 1'b0, 4'h5, 1'b0, 4'h5, 1'b0};
    vecs[1] = '{OP_SUB,  4'h7, 16'hFFFE, 1'b1, 4'hE, 1'b1, 4'h0, 1'b1};
    vecs[2] = '{OP_ADD,  4'h3, 16'h0001, 1'b1, 4'h1, 1'b1, 4'h3, 1'b1};
    vecs[3] = '{OP_SUB,  4'h5, 16'hFFFC, 1'b1, 4'hC, 1'b1, 4'h0, 1'b1};
    vecs[4] = '{OP_RST,  4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0};
    vecs[5] = '{OP_ADD,  4'hE, 16'h000E, 1'b0, 4'hE, 1'b0, 4'hE, 1'b0};
    vecs[6] = '{OP_ADD,  4'hF, 16'h001D, 1'b0, 4'hD, 1'b1, 4'hF, 1'b1};
    vecs[7] = '{OP_SUB,  4'hD, 16'h0010, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1};
    vecs[8] = '{OP_SUB,  4'h5, 16'h000B, 1'b0, 4'hB, 1'b1, 4'h0, 1'b1};
    vecs[9] = '{OP_ADD,  4'h8, 16'h0013, 1'b0, 4'h3, 1'b1, 4'h8, 1'b1};

    rst = 1'b1; dipswitch = 4'h0; suma_btn = 1'b0; resta_btn = 1'b0;
    cyc(3);
    chk("rst_acc", 32'(acc_w16), 32'h0);
    chk("rst_ov", 32'(ov_w16), 32'h0);
    chk("rst_anodo", 32'(an_w16), 32'hF);
    chk("rst_catodo", 32'(cat_w16), 32'h7F);
    rst = 1'b0;
    cyc(1);
    chk("first_anodo", 32'(an_w16), 32'hE);
    chk("first_catodo", 32'(cat_w16), 32'h40);

    // clean press, exact latency, long hold gives one increment
    dipswitch = 4'h1;
    cyc(3);
    suma_btn = 1'b1;
    cyc(6);
    chk("lat_before", 32'(acc_w16), 32'h0);
    cyc(1);
    chk("lat_at7", 32'(acc_w16), 32'h1);
    cyc(43);
    chk("hold_once", 32'(acc_w16), 32'h1);
    suma_btn = 1'b0;
    cyc(10);

    // bouncing press
    dipswitch = 4'h4;
    cyc(3);
    for (int i = 0; i < 10; i++) begin
      suma_btn = ~suma_btn;
      cyc(2);
    end
    chk("bounce_none", 32'(acc_w16), 32'h1);
    suma_btn = 1'b1;
    cyc(12);
    chk("bounce_acc", 32'(acc_w16), 32'h5);
    cyc(30);
    chk("bounce_once", 32'(acc_w16), 32'h5);
    suma_btn = 1'b0;
    cyc(10);

    for (int i = 0; i < 10; i++) do_op(i, vecs[i]);

    // build 0x00A3 then watch a full scan
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) press_add(4'hF);
    press_add(4'hD);
    chk("disp_acc", 32'(acc_w16), 32'h00A3);

    glyph[0] = 7'h30;
    glyph[1] = 7'h08;
`ifdef SUMADOR_LEAD_BLANK_EN
    glyph[2] = 7'h7F;
    glyph[3] = 7'h7F;
`else
    glyph[2] = 7'h40;
    glyph[3] = 7'h40;
`endif
    found   = 1'b0;
    an_prev = an_w16;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(1);
      if (an_prev == 4'b0111 && an_w16 == 4'b1110) found = 1'b1;
      an_prev = an_w16;
    end
    chk("scan_sync", 32'(found), 32'h1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("scan_an_d%0d_c%0d", d, c), 32'(an_w16), 32'(4'hF & ~(4'h1 << d)));
        chk($sformatf("scan_cat_d%0d_c%0d", d, c), 32'(cat_w16), 32'(glyph[d]));
        cyc(1);
      end
    end

    // reset in the middle of digit 2
    cyc(19);
    rst = 1'b1;
    cyc(1);
    chk("midrst_anodo", 32'(an_w16), 32'hF);
    chk("midrst_acc", 32'(acc_w16), 32'h0);
    chk("midrst_catodo", 32'(cat_w16), 32'h7F);
    rst = 1'b0;
    cyc(1);
    chk("post_anodo", 32'(an_w16), 32'hE);
    chk("post_catodo", 32'(cat_w16), 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
